// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM states, next-PC select codes, defaults.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ   = 2'd0,
    SEL_REDIR = 2'd1,
    SEL_PEND  = 2'd2,
    SEL_RESET = 2'd3
  } pc_sel_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd1;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response handshake between the fetch unit and imem.
interface fetch_pc_unit_if;
  logic        fetch_req;
  logic [31:0] fetch_PC;
  logic        imem_ready;
  logic [31:0] imem_data;

  modport master (
    output fetch_req,
    output fetch_PC,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  fetch_req,
    input  fetch_PC,
    output imem_ready,
    output imem_data
  );
endinterface

// File: rtl/fetch_pc_unit_register_en.sv
// Enabled register with synchronous active-low reset to a parameterised value.
module register_en #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC sequencer: owns the fetch PC, drives the imem handshake, holds
// delivered instructions across stalls and flushes F/D and D/X on redirect.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   select_execute_Next_PC,
  input  logic [31:0]            execute_Next_PC,
  fetch_pc_unit_if.master        imem,
  output logic                   fetch_valid,
  output logic [31:0]            fetch_insn,
  output logic [31:0]            fetch_PC_plus1,
  output logic                   flush_FD,
  output logic                   flush_DX
);

  fetch_state_t state, next_state;
  pc_sel_t      pc_sel;
  logic         pc_en, hold_en, pend_en;
  logic [31:0]  pc_q, pc_d, pc_plus, hold_q, pend_q;
  logic         redir;

  assign redir   = select_execute_Next_PC;
  assign pc_plus = pc_q + PC_STEP;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  register_en #(.WIDTH(32), .RESET_VALUE(RESET_PC)) u_pc (
    .clock (clock),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  register_en #(.WIDTH(32), .RESET_VALUE(32'd0)) u_hold (
    .clock (clock),
    .reset (reset),
    .en    (hold_en),
    .d     (imem.imem_data),
    .q     (hold_q)
  );

  register_en #(.WIDTH(32), .RESET_VALUE(32'd0)) u_pend (
    .clock (clock),
    .reset (reset),
    .en    (pend_en),
    .d     (execute_Next_PC),
    .q     (pend_q)
  );

  // Next-PC select (4-input mux)
  always_comb begin
    case (pc_sel)
      SEL_SEQ:   pc_d = pc_plus;
      SEL_REDIR: pc_d = execute_Next_PC;
      SEL_PEND:  pc_d = pend_q;
      default:   pc_d = RESET_PC;
    endcase
  end

  always_comb begin
    next_state     = state;
    pc_en          = 1'b0;
    pc_sel         = SEL_SEQ;
    hold_en        = 1'b0;
    pend_en        = 1'b0;
    imem.fetch_req = 1'b0;
    fetch_valid    = 1'b0;
    fetch_insn     = '0;
    flush_FD       = 1'b0;
    flush_DX       = 1'b0;

    case (state)
      IDLE: begin
        next_state = FETCH;
        if (redir) begin
          pc_en  = 1'b1;
          pc_sel = SEL_REDIR;
        end
      end

      FETCH: begin
        imem.fetch_req = 1'b1;
        flush_FD       = redir;
        flush_DX       = redir;
        if (!imem.imem_ready) begin
          if (redir) begin
            pend_en    = 1'b1;
            next_state = DRAIN;
          end
        end else if (redir) begin
          pc_en  = 1'b1;
          pc_sel = SEL_REDIR;
        end else begin
          fetch_valid = 1'b1;
          fetch_insn  = imem.imem_data;
          if (stall) begin
            hold_en    = 1'b1;
            next_state = HOLD;
          end else begin
            pc_en  = 1'b1;
            pc_sel = SEL_SEQ;
          end
        end
      end

      HOLD: begin
        fetch_valid = !redir;
        fetch_insn  = hold_q;
        flush_FD    = redir;
        flush_DX    = redir;
        if (redir) begin
          pc_en      = 1'b1;
          pc_sel     = SEL_REDIR;
          next_state = FETCH;
        end else if (!stall) begin
          pc_en      = 1'b1;
          pc_sel     = SEL_SEQ;
          next_state = FETCH;
        end
      end

      DRAIN: begin
        // Outstanding request must complete; a same-cycle redirect beats the stored target.
        imem.fetch_req = 1'b1;
        flush_FD       = redir;
        flush_DX       = redir;
        if (redir) begin
          pend_en = 1'b1;
        end
        if (imem.imem_ready) begin
          pc_en      = 1'b1;
          pc_sel     = redir ? SEL_REDIR : SEL_PEND;
          next_state = FETCH;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign imem.fetch_PC  = pc_q;
  assign fetch_PC_plus1 = pc_plus;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed + randomized bench for fetch_pc_unit; two instances (RESET_PC 0 and all-ones) share stimulus.
module tb_fetch_pc_unit;

  logic        clock = 1'b0;
  logic        reset, stall, redir, ready;
  logic [31:0] target;

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  fetch_pc_unit_if bus0 ();
  fetch_pc_unit_if bus1 ();

  assign bus0.imem_ready = ready;
  assign bus1.imem_ready = ready;
  assign bus0.imem_data  = ready ? mem(bus0.fetch_PC) : 32'hBAD0_BAD0;
  assign bus1.imem_data  = ready ? mem(bus1.fetch_PC) : 32'hBAD0_BAD0;

  logic [1:0]        valid, ffd, fdx, req;
  logic [1:0][31:0]  insn, plus1, pcv;

  assign req[0] = bus0.fetch_req;
  assign req[1] = bus1.fetch_req;
  assign pcv[0] = bus0.fetch_PC;
  assign pcv[1] = bus1.fetch_PC;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd1)) dut0 (
    .clock                  (clock),
    .reset                  (reset),
    .stall                  (stall),
    .select_execute_Next_PC (redir),
    .execute_Next_PC        (target),
    .imem                   (bus0),
    .fetch_valid            (valid[0]),
    .fetch_insn             (insn[0]),
    .fetch_PC_plus1         (plus1[0]),
    .flush_FD               (ffd[0]),
    .flush_DX               (fdx[0])
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFF), .PC_STEP(32'd1)) dut1 (
    .clock                  (clock),
    .reset                  (reset),
    .stall                  (stall),
    .select_execute_Next_PC (redir),
    .execute_Next_PC        (target),
    .imem                   (bus1),
    .fetch_valid            (valid[1]),
    .fetch_insn             (insn[1]),
    .fetch_PC_plus1         (plus1[1]),
    .flush_FD               (ffd[1]),
    .flush_DX               (fdx[1])
  );

  // Reference model: architectural PC plus "what is the fetch side doing" flags
  logic [31:0] rst_pc [2] = '{32'h0000_0000, 32'hFFFF_FFFF};
  logic [31:0] m_pc   [2];
  logic [31:0] m_pend [2];
  logic        m_known[2] = '{1'b0, 1'b0};
  logic        m_idle [2];
  logic        m_held [2];
  logic        m_drain[2];

  task automatic chk(input string tag, input int unsigned d,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
  endtask

  task automatic cyc(input logic r, input logic s, input logic rd,
                     input logic [31:0] t, input logic rdy);
    logic e_req, e_valid, e_flush;
    reset = r; stall = s; redir = rd; target = t; ready = rdy;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      if (m_known[d]) begin
        if (m_idle[d]) begin
          e_req = 1'b0; e_valid = 1'b0; e_flush = 1'b0;
          chk("idle_insn", d, insn[d], 32'd0);
        end else if (m_held[d]) begin
          e_req = 1'b0; e_valid = !rd; e_flush = rd;
        end else if (m_drain[d]) begin
          e_req = 1'b1; e_valid = 1'b0; e_flush = rd;
        end else begin
          e_req = 1'b1; e_valid = rdy && !rd; e_flush = rd;
        end
        chk("fetch_req", d, {31'd0, req[d]}, {31'd0, e_req});
        chk("fetch_PC", d, pcv[d], m_pc[d]);
        chk("pc_plus1", d, plus1[d], m_pc[d] + 32'd1);
        chk("fetch_valid", d, {31'd0, valid[d]}, {31'd0, e_valid});
        chk("flush_FD", d, {31'd0, ffd[d]}, {31'd0, e_flush});
        chk("flush_DX", d, {31'd0, fdx[d]}, {31'd0, e_flush});
        if (e_valid) chk("fetch_insn", d, insn[d], mem(m_pc[d]));
      end
      if (!r) begin
        m_pc[d] = rst_pc[d]; m_pend[d] = '0; m_known[d] = 1'b1;
        m_idle[d] = 1'b1; m_held[d] = 1'b0; m_drain[d] = 1'b0;
      end else if (m_idle[d]) begin
        m_idle[d] = 1'b0;
        if (rd) m_pc[d] = t;
      end else if (m_held[d]) begin
        if (rd) begin m_pc[d] = t; m_held[d] = 1'b0; end
        else if (!s) begin m_pc[d] = m_pc[d] + 32'd1; m_held[d] = 1'b0; end
      end else if (m_drain[d]) begin
        if (rdy) begin m_pc[d] = rd ? t : m_pend[d]; m_drain[d] = 1'b0; end
        else if (rd) m_pend[d] = t;
      end else if (rdy) begin
        if (rd) m_pc[d] = t;
        else if (s) m_held[d] = 1'b1;
        else m_pc[d] = m_pc[d] + 32'd1;
      end else if (rd) begin
        m_drain[d] = 1'b1; m_pend[d] = t;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redir = 1'b0; target = '0; ready = 1'b1;

    // Reset for two cycles
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_pc", 0, pcv[0], 32'h0000_0000);
    chk("rst_req", 0, {31'd0, req[0]}, 32'd0);
    chk("rst_pc", 1, pcv[1], 32'hFFFF_FFFF);
    chk("rst_plus1_wrap", 1, plus1[1], 32'd0);

    // Zero-wait sequential fetch
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("seq_pc", 0, pcv[0], i);
      cyc(1, 0, 0, 0, 1);
    end
    chk("wrap_seq_pc", 1, pcv[1], 32'd4);

    // Stall at PC=5 for three cycles
    cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      chk("hold_req", 0, {31'd0, req[0]}, 32'd0);
      chk("hold_plus1", 0, plus1[0], 32'd6);
      chk("hold_insn", 0, insn[0], mem(32'd5));
      cyc(1, 1, 0, 0, 1);
    end
    cyc(1, 0, 0, 0, 1);
    chk("after_hold_pc", 0, pcv[0], 32'd6);

    // Redirect with ready
    cyc(1, 0, 1, 32'h40, 1);
    chk("redir_pc", 0, pcv[0], 32'h40);

    // Drain with two redirects; newest wins
    cyc(1, 0, 1, 32'd9, 1);
    chk("pre_drain_pc", 0, pcv[0], 32'd9);
    cyc(1, 0, 1, 32'h80, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h90, 0);
    chk("drain_pc_stable", 0, pcv[0], 32'd9);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("drain_target", 0, pcv[0], 32'h90);

    // Redirect and stall together while holding
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 1, 32'h123, 1);
    chk("hold_redir_pc", 0, pcv[0], 32'h123);

    // PC wrap at all-ones
    cyc(1, 0, 1, 32'hFFFF_FFFF, 1);
    chk("wrap_plus1", 0, plus1[0], 32'd0);
    cyc(1, 0, 0, 0, 1);
    chk("wrap_pc", 0, pcv[0], 32'd0);

    // Reset pulsed during DRAIN
    cyc(1, 0, 1, 32'h55, 0);
    cyc(0, 0, 0, 0, 1);
    chk("drain_rst_pc", 0, pcv[0], 32'd0);
    chk("drain_rst_pc", 1, pcv[1], 32'hFFFF_FFFF);
    chk("drain_rst_req", 0, {31'd0, req[0]}, 32'd0);
    cyc(1, 0, 0, 0, 1);
    chk("post_idle_pc", 0, pcv[0], 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(99) != 0),
          ($urandom_range(9) < 3),
          ($urandom_range(9) == 0),
          $urandom,
          ($urandom_range(9) < 7));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
